// File: rtl/nibble_exec_unit_pkg.sv
// Shared ISA definitions for the nibble accumulator machine: opcodes and FSM states.
package nibble_exec_unit_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LIT  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_IN   = 4'd7;
    localparam logic [3:0] OP_OUT  = 4'd8;
    localparam logic [3:0] OP_PGH  = 4'd9;
    localparam logic [3:0] OP_PGL  = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;
    localparam logic [3:0] OP_JMP  = 4'd12;
    localparam logic [3:0] OP_JZ   = 4'd13;
    localparam logic [3:0] OP_JC   = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_exec_unit_alu.sv
// Combinational ALU for the nibble machine: computes the result and which of acc/C/Z it writes.
module nibble_alu
    import nibble_exec_unit_pkg::*;
(
    input  logic [3:0] acc,
    input  logic [3:0] oprnd,
    input  logic [3:0] op,
    output logic [3:0] result,
    output logic       c_out,
    output logic       z_out,
    output logic       wr_acc,
    output logic       wr_c,
    output logic       wr_z
);

    logic [4:0] sum;
    logic [4:0] diff;

    assign sum  = {1'b0, acc} + {1'b0, oprnd};
    assign diff = {1'b0, acc} - {1'b0, oprnd};

    always_comb begin
        result = acc;
        c_out  = 1'b0;
        wr_acc = 1'b0;
        wr_c   = 1'b0;
        wr_z   = 1'b0;
        case (op)
            OP_LIT, OP_IN: begin
                result = oprnd;
                wr_acc = 1'b1;
                wr_z   = 1'b1;
            end
            OP_ADD: begin
                result = sum[3:0];
                c_out  = sum[4];
                wr_acc = 1'b1;
                wr_c   = 1'b1;
                wr_z   = 1'b1;
            end
            // No borrow out of the 5-bit difference means acc >= oprnd.
            OP_SUB, OP_CMP: begin
                result = diff[3:0];
                c_out  = ~diff[4];
                wr_acc = (op == OP_SUB);
                wr_c   = 1'b1;
                wr_z   = 1'b1;
            end
            OP_AND: begin
                result = acc & oprnd;
                wr_acc = 1'b1;
                wr_z   = 1'b1;
            end
            OP_OR: begin
                result = acc | oprnd;
                wr_acc = 1'b1;
                wr_z   = 1'b1;
            end
            OP_XOR: begin
                result = acc ^ oprnd;
                wr_acc = 1'b1;
                wr_z   = 1'b1;
            end
            default: ;
        endcase
    end

    assign z_out = (result == 4'd0);

endmodule

// File: rtl/nibble_exec_unit.sv
// Execute/control stage: fetch/exec/halt FSM, accumulator machine state and PC strobe decode.
module nibble_exec_unit
    import nibble_exec_unit_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter logic [7:0]  PAGE_RST = 8'h00
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              run,
    input  logic [3:0]        instr,
    input  logic [3:0]        oprnd,
    input  logic [3:0]        in_data,
    output logic              fetch_en,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic [3:0]        acc,
    output logic              flag_c,
    output logic              flag_z,
    output logic [3:0]        out_data,
    output logic              out_strobe,
    output logic              halted
);

    state_e     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic       flag_c_q, flag_c_d;
    logic       flag_z_q, flag_z_d;
    logic [3:0] out_data_q, out_data_d;
    logic       out_strobe_q, out_strobe_d;
    logic [3:0] page_hi_q, page_hi_d;
    logic [3:0] page_lo_q, page_lo_d;

    logic [3:0] alu_opnd;
    logic [3:0] alu_result;
    logic       alu_c, alu_z, alu_wr_acc, alu_wr_c, alu_wr_z;

    // IN reuses the ALU's load path with the external port as the operand.
    assign alu_opnd = (instr == OP_IN) ? in_data : oprnd;

    nibble_alu u_alu (
        .acc    (acc_q),
        .oprnd  (alu_opnd),
        .op     (instr),
        .result (alu_result),
        .c_out  (alu_c),
        .z_out  (alu_z),
        .wr_acc (alu_wr_acc),
        .wr_c   (alu_wr_c),
        .wr_z   (alu_wr_z)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        flag_c_d     = flag_c_q;
        flag_z_d     = flag_z_q;
        out_data_d   = out_data_q;
        out_strobe_d = 1'b0;
        page_hi_d    = page_hi_q;
        page_lo_d    = page_lo_q;
        fetch_en     = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    fetch_en = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_inc  = 1'b1;
                if (alu_wr_acc) acc_d    = alu_result;
                if (alu_wr_c)   flag_c_d = alu_c;
                if (alu_wr_z)   flag_z_d = alu_z;
                case (instr)
                    OP_OUT: begin
                        out_data_d   = acc_q;
                        out_strobe_d = 1'b1;
                    end
                    OP_PGH: page_hi_d = oprnd;
                    OP_PGL: page_lo_d = oprnd;
                    OP_JMP: begin
                        pc_inc  = 1'b0;
                        pc_load = 1'b1;
                    end
                    // Conditional branches look at the flags registered before this cycle.
                    OP_JZ: begin
                        pc_inc  = ~flag_z_q;
                        pc_load = flag_z_q;
                    end
                    OP_JC: begin
                        pc_inc  = ~flag_c_q;
                        pc_load = flag_c_q;
                    end
                    OP_HALT: begin
                        pc_inc  = 1'b0;
                        state_d = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase
        // A reset in the same cycle squashes every strobe to the upstream path.
        if (reset) begin
            fetch_en = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            acc_q        <= 4'd0;
            flag_c_q     <= 1'b0;
            flag_z_q     <= 1'b0;
            out_data_q   <= 4'd0;
            out_strobe_q <= 1'b0;
            page_hi_q    <= PAGE_RST[7:4];
            page_lo_q    <= PAGE_RST[3:0];
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            flag_c_q     <= flag_c_d;
            flag_z_q     <= flag_z_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
            page_hi_q    <= page_hi_d;
            page_lo_q    <= page_lo_d;
        end
    end

    assign pc_target  = {page_hi_q, page_lo_q, oprnd};
    assign acc        = acc_q;
    assign flag_c     = flag_c_q;
    assign flag_z     = flag_z_q;
    assign out_data   = out_data_q;
    assign out_strobe = out_strobe_q;
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_nibble_exec_unit.sv
// Self-checking bench for nibble_exec_unit: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_nibble_exec_unit;

    logic        Clk = 1'b0;
    logic        reset, run;
    logic [3:0]  instr, oprnd, in_data;
    logic        fetch_en, pc_inc, pc_load;
    logic [11:0] pc_target;
    logic [3:0]  acc;
    logic        flag_c, flag_z;
    logic [3:0]  out_data;
    logic        out_strobe, halted;

    nibble_exec_unit #(.ADDR_W(12), .PAGE_RST(8'h00)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .run        (run),
        .instr      (instr),
        .oprnd      (oprnd),
        .in_data    (in_data),
        .fetch_en   (fetch_en),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .acc        (acc),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .halted     (halted)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: phase 0 = waiting to fetch, 1 = executing, 2 = halted.
    int m_phase, m_acc, m_c, m_z, m_out, m_strobe, m_ph, m_pl;

    logic        obs_fe, obs_inc, obs_ld;
    logic [11:0] obs_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic r, input logic [3:0] op,
                        input logic [3:0] opr, input logic [3:0] ind);
        int e_fe, e_inc, e_ld, a, o, s;
        @(negedge Clk);
        reset = rst; run = r; instr = op; oprnd = opr; in_data = ind;
        #1;
        e_fe = (!rst && m_phase == 0 && r) ? 1 : 0;
        e_inc = 0;
        e_ld  = 0;
        if (!rst && m_phase == 1) begin
            case (int'(op))
                12:      e_ld = 1;
                13:      if (m_z != 0) e_ld = 1; else e_inc = 1;
                14:      if (m_c != 0) e_ld = 1; else e_inc = 1;
                15:      ;
                default: e_inc = 1;
            endcase
        end
        obs_fe = fetch_en; obs_inc = pc_inc; obs_ld = pc_load; obs_tgt = pc_target;
        chk("fetch_en", fetch_en, e_fe);
        chk("pc_inc", pc_inc, e_inc);
        chk("pc_load", pc_load, e_ld);
        if (e_ld != 0) chk("pc_target", pc_target, m_ph * 256 + m_pl * 16 + int'(opr));

        @(posedge Clk);
        #1;
        a = m_acc;
        o = int'(opr);
        m_strobe = 0;
        if (rst) begin
            m_phase = 0; m_acc = 0; m_c = 0; m_z = 0; m_out = 0; m_ph = 0; m_pl = 0;
        end else if (m_phase == 0) begin
            if (r) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 0;
            case (int'(op))
                1:  begin m_acc = o; m_z = (m_acc == 0); end
                2:  begin s = a + o; m_c = (s > 15); m_acc = s % 16; m_z = (m_acc == 0); end
                3:  begin m_c = (a >= o); m_acc = (a - o + 16) % 16; m_z = (m_acc == 0); end
                4:  begin m_acc = a & o; m_z = (m_acc == 0); end
                5:  begin m_acc = a | o; m_z = (m_acc == 0); end
                6:  begin m_acc = a ^ o; m_z = (m_acc == 0); end
                7:  begin m_acc = int'(ind); m_z = (m_acc == 0); end
                8:  begin m_out = a; m_strobe = 1; end
                9:  m_ph = o;
                10: m_pl = o;
                11: begin m_c = (a >= o); m_z = (a == o); end
                15: m_phase = 2;
                default: ;
            endcase
        end
        chk("acc", acc, m_acc);
        chk("flag_c", flag_c, m_c);
        chk("flag_z", flag_z, m_z);
        chk("out_data", out_data, m_out);
        chk("out_strobe", out_strobe, m_strobe);
        chk("halted", halted, (m_phase == 2) ? 1 : 0);
    endtask

    // One full instruction: fetch cycle then execute cycle, both with run high.
    task automatic ex(input logic [3:0] op, input logic [3:0] opr, input logic [3:0] ind);
        step(1'b0, 1'b1, op, opr, ind);
        step(1'b0, 1'b1, op, opr, ind);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rr, rs;
        logic [3:0] rop, ropr, rin;
        m_phase = 0; m_acc = 0; m_c = 0; m_z = 0; m_out = 0; m_strobe = 0; m_ph = 0; m_pl = 0;
        reset = 1'b1; run = 1'b0; instr = 4'd0; oprnd = 4'd0; in_data = 4'd0;

        // 1: reset, then strictly alternating fetch/inc strobes
        step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
        chk("pin_reset_acc", acc, 4'd0);
        chk("pin_reset_halted", halted, 1'b0);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        chk("pin_c1_fetch_en", obs_fe, 1'b1);
        chk("pin_c1_pc_inc", obs_inc, 1'b0);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        chk("pin_c2_pc_inc", obs_inc, 1'b1);
        chk("pin_c2_fetch_en", obs_fe, 1'b0);

        // 2: LIT 9, ADD 8 wraps with carry; SUB 1 reaches zero without borrow
        ex(4'd1, 4'd9, 4'd0);
        ex(4'd2, 4'd8, 4'd0);
        chk("pin_add_acc", acc, 4'd1);
        chk("pin_add_c", flag_c, 1'b1);
        chk("pin_add_z", flag_z, 1'b0);
        ex(4'd3, 4'd1, 4'd0);
        chk("pin_sub_acc", acc, 4'd0);
        chk("pin_sub_c", flag_c, 1'b1);
        chk("pin_sub_z", flag_z, 1'b1);

        // 3: paged jump
        ex(4'd9, 4'd2, 4'd0);
        ex(4'd10, 4'hA, 4'd0);
        ex(4'd12, 4'd5, 4'd0);
        chk("pin_jmp_load", obs_ld, 1'b1);
        chk("pin_jmp_target", obs_tgt, 12'h2A5);
        chk("pin_jmp_inc", obs_inc, 1'b0);

        // 4: CMP borrow, JC not taken, JZ taken
        ex(4'd1, 4'd3, 4'd0);
        ex(4'd11, 4'd4, 4'd0);
        chk("pin_cmp_c", flag_c, 1'b0);
        chk("pin_cmp_acc", acc, 4'd3);
        ex(4'd14, 4'd7, 4'd0);
        chk("pin_jc_inc", obs_inc, 1'b1);
        chk("pin_jc_load", obs_ld, 1'b0);
        ex(4'd1, 4'd0, 4'd0);
        ex(4'd13, 4'd1, 4'd0);
        chk("pin_jz_load", obs_ld, 1'b1);
        chk("pin_jz_target", obs_tgt, 12'h2A1);

        // 5: IN, OUT pulse, HALT sticks with run high
        ex(4'd7, 4'd0, 4'hC);
        ex(4'd8, 4'd0, 4'd0);
        chk("pin_out_data", out_data, 4'hC);
        chk("pin_out_strobe", out_strobe, 1'b1);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        chk("pin_out_strobe_off", out_strobe, 1'b0);
        step(1'b0, 1'b1, 4'd15, 4'd0, 4'd0);
        chk("pin_halted", halted, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'd0);
        chk("pin_still_halted", halted, 1'b1);

        // 6: stall, then reset in the middle of an ADD execute
        step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd2, 4'd5, 4'd0);
        step(1'b0, 1'b1, 4'd2, 4'd5, 4'd0);
        step(1'b1, 1'b1, 4'd2, 4'd5, 4'd0);
        chk("pin_rst_exec_inc", obs_inc, 1'b0);
        chk("pin_rst_exec_acc", acc, 4'd0);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        chk("pin_rst_exec_fetch", obs_fe, 1'b1);
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);

        // Randomized traffic; halts are rarer and released by reset
        for (int i = 0; i < 1500; i++) begin
            rs   = ($urandom_range(60) == 0) || (m_phase == 2 && $urandom_range(6) == 0);
            rr   = ($urandom_range(3) != 0);
            rop  = 4'($urandom_range(15));
            if (rop == 4'd15 && $urandom_range(3) != 0) rop = 4'd2;
            ropr = 4'($urandom_range(15));
            rin  = 4'($urandom_range(15));
            step(rs, rr, rop, ropr, rin);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
